// File: rtl/ysyx_22041461_if_ctrl_pkg.sv
// Shared definitions for the fetch-stage sequencer: FSM encoding, reset PC
// and the redirect source priority (trap > mret > jump).
package ysyx_22041461_if_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HOLD = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DROP = 3'd3,
        ST_FULL = 3'd4
    } if_state_e;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JUMP = 2'd1,
        SRC_MRET = 2'd2,
        SRC_TRAP = 2'd3
    } redir_src_e;

    function automatic redir_src_e redir_pick(input logic trap, input logic mret, input logic jump);
        redir_src_e src;
        if (trap)      src = SRC_TRAP;
        else if (mret) src = SRC_MRET;
        else if (jump) src = SRC_JUMP;
        else           src = SRC_NONE;
        return src;
    endfunction

endpackage

// File: rtl/ysyx_22041461_redirect_sel.sv
// Combinational redirect arbiter: merges trap, mret and EX jump requests into a
// single redirect flag and the highest-priority target.
module ysyx_22041461_redirect_sel
    import ysyx_22041461_if_ctrl_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              trap_valid_i,
    input  logic [ADDR_W-1:0] trap_target_i,
    input  logic              mret_valid_i,
    input  logic [ADDR_W-1:0] mret_target_i,
    input  logic              jump_valid_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] pc_next_o
);

    redir_src_e src;

    assign src        = redir_pick(trap_valid_i, mret_valid_i, jump_valid_i);
    assign redirect_o = (src != SRC_NONE);

    always_comb begin
        pc_next_o = '0;
        unique case (src)
            SRC_TRAP: pc_next_o = trap_target_i;
            SRC_MRET: pc_next_o = mret_target_i;
            SRC_JUMP: pc_next_o = jump_target_i;
            default:  pc_next_o = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22041461_if_ctrl.sv
// Fetch-stage sequencer: issues one instruction fetch at a time at the current
// PC, buffers the result for ID and steers the PC register (+4 or redirect).
module ysyx_22041461_if_ctrl
    import ysyx_22041461_if_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int INST_W   = 32,
    parameter int RST_HOLD = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              trap_valid_i,
    input  logic [ADDR_W-1:0] trap_target_i,
    input  logic              mret_valid_i,
    input  logic [ADDR_W-1:0] mret_target_i,
    input  logic              jump_valid_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    output logic              imem_req_valid_o,
    output logic [ADDR_W-1:0] imem_req_addr_o,
    input  logic              imem_req_ready_i,
    input  logic              imem_resp_valid_i,
    input  logic [INST_W-1:0] imem_resp_data_i,
    output logic              id_valid_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic [ADDR_W-1:0] id_pc_o,
    input  logic              id_ready_i,
    output logic              pc_enable_o,
    output logic              pc_ctrl_o,
    output logic [ADDR_W-1:0] pc_next_o
);

    localparam int              HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    if_state_e          state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               id_valid_q, id_valid_d;
    logic [INST_W-1:0]  id_inst_q, id_inst_d;
    logic [ADDR_W-1:0]  id_pc_q, id_pc_d;

    logic               redirect;
    logic [ADDR_W-1:0]  redir_target;

    ysyx_22041461_redirect_sel #(
        .ADDR_W (ADDR_W)
    ) u_redirect_sel (
        .trap_valid_i  (trap_valid_i),
        .trap_target_i (trap_target_i),
        .mret_valid_i  (mret_valid_i),
        .mret_target_i (mret_target_i),
        .jump_valid_i  (jump_valid_i),
        .jump_target_i (jump_target_i),
        .redirect_o    (redirect),
        .pc_next_o     (redir_target)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            id_valid_q <= 1'b0;
            id_inst_q  <= '0;
            id_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        hold_cnt_d       = hold_cnt_q;
        id_valid_d       = id_valid_q;
        id_inst_d        = id_inst_q;
        id_pc_d          = id_pc_q;
        imem_req_valid_o = 1'b0;
        pc_enable_o      = 1'b0;
        pc_ctrl_o        = 1'b0;
        pc_next_o        = '0;

        // The PC register is still coming out of reset during HOLD, so redirects are dropped there.
        if (redirect && (state_q != ST_HOLD)) begin
            pc_enable_o = 1'b1;
            pc_ctrl_o   = 1'b1;
            pc_next_o   = redir_target;
            id_valid_d  = 1'b0;
        end

        unique case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) state_d = ST_REQ;
                else                         hold_cnt_d = hold_cnt_q + 1'b1;
            end
            ST_REQ: begin
                imem_req_valid_o = 1'b1;
                if (imem_req_ready_i) state_d = redirect ? ST_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_resp_valid_i) begin
                    if (redirect) begin
                        state_d = ST_REQ;
                    end else begin
                        id_inst_d   = imem_resp_data_i;
                        id_pc_d     = pc_i;
                        id_valid_d  = 1'b1;
                        pc_enable_o = 1'b1;
                        pc_ctrl_o   = 1'b0;
                        state_d     = ST_FULL;
                    end
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
            end
            // Stale request still outstanding: swallow its response before fetching again.
            ST_DROP: begin
                if (imem_resp_valid_i) state_d = ST_REQ;
            end
            ST_FULL: begin
                if (redirect || id_ready_i) begin
                    id_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    assign imem_req_addr_o = pc_i;
    assign id_valid_o      = id_valid_q;
    assign id_inst_o       = id_inst_q;
    assign id_pc_o         = id_pc_q;

endmodule

// File: tb/tb_ysyx_22041461_if_ctrl.sv
// Directed bench for the fetch sequencer with a behavioural PC register
// closing the loop around pc_enable/pc_ctrl/pc_next.
module tb_ysyx_22041461_if_ctrl;
    import ysyx_22041461_if_ctrl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [63:0] pc_i;
    logic        trap_valid_i, mret_valid_i, jump_valid_i;
    logic [63:0] trap_target_i, mret_target_i, jump_target_i;
    logic        imem_req_valid_o;
    logic [63:0] imem_req_addr_o;
    logic        imem_req_ready_i, imem_resp_valid_i;
    logic [31:0] imem_resp_data_i;
    logic        id_valid_o;
    logic [31:0] id_inst_o;
    logic [63:0] id_pc_o;
    logic        id_ready_i;
    logic        pc_enable_o, pc_ctrl_o;
    logic [63:0] pc_next_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          pc_i <= RESET_PC;
        else if (pc_enable_o) pc_i <= pc_ctrl_o ? pc_next_o : pc_i + 64'd4;
    end

    ysyx_22041461_if_ctrl #(
        .ADDR_W   (64),
        .INST_W   (32),
        .RST_HOLD (2)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .pc_i              (pc_i),
        .trap_valid_i      (trap_valid_i),
        .trap_target_i     (trap_target_i),
        .mret_valid_i      (mret_valid_i),
        .mret_target_i     (mret_target_i),
        .jump_valid_i      (jump_valid_i),
        .jump_target_i     (jump_target_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .id_valid_o        (id_valid_o),
        .id_inst_o         (id_inst_o),
        .id_pc_o           (id_pc_o),
        .id_ready_i        (id_ready_i),
        .pc_enable_o       (pc_enable_o),
        .pc_ctrl_o         (pc_ctrl_o),
        .pc_next_o         (pc_next_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        trap_valid_i = 0; mret_valid_i = 0; jump_valid_i = 0;
        trap_target_i = '0; mret_target_i = '0; jump_target_i = '0;
        imem_req_ready_i = 1; imem_resp_valid_i = 0; imem_resp_data_i = '0;
        id_ready_i = 0;
        #2;
        check("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
        check("rst_id_valid",  64'(id_valid_o), 64'd0);
        check("rst_id_inst",   64'(id_inst_o), 64'd0);
        check("rst_id_pc",     id_pc_o, 64'd0);
        check("rst_pc_enable", 64'(pc_enable_o), 64'd0);
        check("rst_pc_ctrl",   64'(pc_ctrl_o), 64'd0);
        check("rst_pc_next",   pc_next_o, 64'd0);
        #10;
        rst_ni = 1'b1;

        // HOLD: redirect ignored
        jump_valid_i = 1; jump_target_i = 64'h123;
        #1;
        check("hold_pc_enable", 64'(pc_enable_o), 64'd0);
        check("hold_pc_next",   pc_next_o, 64'd0);
        tick();
        jump_valid_i = 0;
        #1;
        check("hold1_req_valid", 64'(imem_req_valid_o), 64'd0);
        tick();
        // REQ, second edge after release
        #1;
        check("req0_valid", 64'(imem_req_valid_o), 64'd1);
        check("req0_addr",  imem_req_addr_o, 64'h8000_0000);
        tick();
        // WAIT with 1-cycle response
        imem_resp_valid_i = 1; imem_resp_data_i = 32'h0000_0013;
        #1;
        check("wait0_pc_enable", 64'(pc_enable_o), 64'd1);
        check("wait0_pc_ctrl",   64'(pc_ctrl_o), 64'd0);
        check("wait0_id_valid",  64'(id_valid_o), 64'd0);
        tick();
        imem_resp_valid_i = 0;
        #1;
        check("full0_id_valid", 64'(id_valid_o), 64'd1);
        check("full0_id_inst",  64'(id_inst_o), 64'h13);
        check("full0_id_pc",    id_pc_o, 64'h8000_0000);

        // FULL stall for 5 cycles
        for (int i = 0; i < 5; i++) begin
            check("stall_id_valid",  64'(id_valid_o), 64'd1);
            check("stall_id_inst",   64'(id_inst_o), 64'h13);
            check("stall_id_pc",     id_pc_o, 64'h8000_0000);
            check("stall_req_valid", 64'(imem_req_valid_o), 64'd0);
            tick();
        end
        id_ready_i = 1;
        tick();
        id_ready_i = 0;
        #1;
        check("req1_valid",    64'(imem_req_valid_o), 64'd1);
        check("req1_addr",     imem_req_addr_o, 64'h8000_0004);
        check("req1_id_valid", 64'(id_valid_o), 64'd0);
        tick();

        // WAIT: jump before response -> DROP
        jump_valid_i = 1; jump_target_i = 64'h8000_0100;
        #1;
        check("wjmp_pc_enable", 64'(pc_enable_o), 64'd1);
        check("wjmp_pc_ctrl",   64'(pc_ctrl_o), 64'd1);
        check("wjmp_pc_next",   pc_next_o, 64'h8000_0100);
        tick();
        jump_valid_i = 0;
        imem_resp_valid_i = 1; imem_resp_data_i = 32'hDEAD_BEEF;
        #1;
        check("drop_req_valid", 64'(imem_req_valid_o), 64'd0);
        check("drop_pc_enable", 64'(pc_enable_o), 64'd0);
        tick();
        imem_resp_valid_i = 0;
        #1;
        check("drop_id_valid", 64'(id_valid_o), 64'd0);
        check("req2_valid",    64'(imem_req_valid_o), 64'd1);
        check("req2_addr",     imem_req_addr_o, 64'h8000_0100);

        // Priority, REQ not ready
        imem_req_ready_i = 0;
        trap_valid_i = 1; trap_target_i = 64'h8000_0800;
        mret_valid_i = 1; mret_target_i = 64'h8000_0400;
        jump_valid_i = 1; jump_target_i = 64'h8000_0100;
        #1;
        check("prio_trap", pc_next_o, 64'h8000_0800);
        check("prio_ctrl", 64'(pc_ctrl_o), 64'd1);
        trap_valid_i = 0;
        #1;
        check("prio_mret", pc_next_o, 64'h8000_0400);
        tick();
        mret_valid_i = 0; jump_valid_i = 0;
        #1;
        check("req3_addr", imem_req_addr_o, 64'h8000_0400);

        // Not ready for 4 cycles, then redirect while still not ready
        for (int i = 0; i < 4; i++) begin
            check("nrdy_req_valid", 64'(imem_req_valid_o), 64'd1);
            check("nrdy_pc_enable", 64'(pc_enable_o), 64'd0);
            tick();
        end
        jump_valid_i = 1; jump_target_i = 64'h8000_0200;
        #1;
        check("nrdy_jmp_next", pc_next_o, 64'h8000_0200);
        tick();
        jump_valid_i = 0; imem_req_ready_i = 1;
        #1;
        check("req4_valid", 64'(imem_req_valid_o), 64'd1);
        check("req4_addr",  imem_req_addr_o, 64'h8000_0200);
        tick();
        imem_resp_valid_i = 1; imem_resp_data_i = 32'h0010_0093;
        #1;
        check("wait4_pc_enable", 64'(pc_enable_o), 64'd1);
        check("wait4_pc_ctrl",   64'(pc_ctrl_o), 64'd0);
        tick();
        imem_resp_valid_i = 0;
        #1;
        check("full4_id_valid", 64'(id_valid_o), 64'd1);
        check("full4_id_inst",  64'(id_inst_o), 64'h0010_0093);
        check("full4_id_pc",    id_pc_o, 64'h8000_0200);

        // FULL: redirect beats id_ready
        id_ready_i = 1; jump_valid_i = 1; jump_target_i = 64'h8000_0300;
        #1;
        check("fjmp_pc_ctrl", 64'(pc_ctrl_o), 64'd1);
        check("fjmp_pc_next", pc_next_o, 64'h8000_0300);
        tick();
        id_ready_i = 0; jump_valid_i = 0;
        #1;
        check("req5_id_valid", 64'(id_valid_o), 64'd0);
        check("req5_addr",     imem_req_addr_o, 64'h8000_0300);

        // REQ accepted with redirect -> DROP; redirect inside DROP
        mret_valid_i = 1; mret_target_i = 64'h8000_0500;
        #1;
        check("rmret_pc_next", pc_next_o, 64'h8000_0500);
        tick();
        mret_valid_i = 0;
        jump_valid_i = 1; jump_target_i = 64'h8000_0600;
        #1;
        check("drop2_req_valid", 64'(imem_req_valid_o), 64'd0);
        check("drop2_pc_enable", 64'(pc_enable_o), 64'd1);
        check("drop2_pc_next",   pc_next_o, 64'h8000_0600);
        tick();
        jump_valid_i = 0;
        #1;
        check("drop3_req_valid", 64'(imem_req_valid_o), 64'd0);
        imem_resp_valid_i = 1; imem_resp_data_i = 32'h1111_1111;
        tick();
        imem_resp_valid_i = 0;
        #1;
        check("req6_valid",    64'(imem_req_valid_o), 64'd1);
        check("req6_addr",     imem_req_addr_o, 64'h8000_0600);
        check("req6_id_valid", 64'(id_valid_o), 64'd0);
        tick();

        // WAIT: response and trap together -> response discarded, back to REQ
        imem_resp_valid_i = 1; imem_resp_data_i = 32'h2222_2222;
        trap_valid_i = 1; trap_target_i = 64'h8000_0800;
        #1;
        check("wtrap_pc_ctrl", 64'(pc_ctrl_o), 64'd1);
        check("wtrap_pc_next", pc_next_o, 64'h8000_0800);
        tick();
        imem_resp_valid_i = 0; trap_valid_i = 0;
        #1;
        check("req7_id_valid", 64'(id_valid_o), 64'd0);
        check("req7_valid",    64'(imem_req_valid_o), 64'd1);
        check("req7_addr",     imem_req_addr_o, 64'h8000_0800);
        tick();

        // Reset while in WAIT
        #1;
        rst_ni = 1'b0;
        #1;
        check("mrst_req_valid", 64'(imem_req_valid_o), 64'd0);
        check("mrst_id_valid",  64'(id_valid_o), 64'd0);
        check("mrst_pc_enable", 64'(pc_enable_o), 64'd0);
        check("mrst_id_pc",     id_pc_o, 64'd0);
        #1;
        rst_ni = 1'b1;
        imem_resp_valid_i = 1; imem_resp_data_i = 32'h5555_5555;
        #1;
        check("late_pc_enable", 64'(pc_enable_o), 64'd0);
        tick();
        #1;
        check("late_id_valid",  64'(id_valid_o), 64'd0);
        check("late_req_valid", 64'(imem_req_valid_o), 64'd0);
        tick();
        imem_resp_valid_i = 0;
        #1;
        check("rreq_valid",    64'(imem_req_valid_o), 64'd1);
        check("rreq_addr",     imem_req_addr_o, 64'h8000_0000);
        check("rreq_id_valid", 64'(id_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22041461_if_ctrl.md
Name: ysyx_22041461_if_ctrl

Overview:
- Fetch-stage sequencer for the PC register. It issues instruction-memory requests at the current PC and buffers each returned instruction for ID.
- Drives the PC register's enable/ctrl/next-PC inputs: sequential +4 on a completed fetch, or a redirect target.
- Arbitrates redirect sources (trap > mret > EX jump/branch) and discards in-flight fetches made stale by a redirect.

Parameters:
ADDR_W, 64, PC/address width
INST_W, 32, instruction width
RST_HOLD, 2, cycles held idle after reset release, covering the PC register's 2-stage reset synchroniser

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
pc  in  ADDR_W  current PC from PC register
trap_valid  in  1  trap redirect pulse
trap_target  in  ADDR_W  trap vector
mret_valid  in  1  mret redirect pulse
mret_target  in  ADDR_W  mepc
jump_valid  in  1  EX jump/branch-taken pulse
jump_target  in  ADDR_W  EX target
imem_req_valid  out  1  fetch request
imem_req_addr  out  ADDR_W  fetch address (= pc)
imem_req_ready  in  1  memory accepts request
imem_resp_valid  in  1  instruction returned
imem_resp_data  in  INST_W  instruction
id_valid  out  1  buffered instruction valid
id_inst  out  INST_W  buffered instruction
id_pc  out  ADDR_W  PC of buffered instruction
id_ready  in  1  ID consumes buffer
pc_enable  out  1  PC register update enable
pc_ctrl  out  1  0: PC+4, 1: load pc_next
pc_next  out  ADDR_W  redirect target

Behaviour:
- Reset (rst low, async): state HOLD, hold counter=0, id_valid=0, id_inst=0, id_pc=0, imem_req_valid=0, pc_enable=0, pc_ctrl=0, pc_next=0.
- Redirect select (combinational): redirect = trap_valid | mret_valid | jump_valid. Target priority is trap > mret > jump. On redirect in any state except HOLD: pc_enable=1, pc_ctrl=1, pc_next=selected target, id_valid cleared next cycle. Redirects during HOLD are ignored.
- States:
  - HOLD: counter increments each cycle; at RST_HOLD-1 -> REQ. No outputs asserted.
  - REQ: imem_req_valid=1, imem_req_addr=pc.
    - ready && !redirect -> WAIT.
    - ready && redirect -> DROP (issued request is stale).
    - !ready && redirect -> REQ (next cycle uses new pc).
  - WAIT: await response.
    - resp_valid && !redirect: latch id_inst=resp_data, id_pc=pc, id_valid=1; pc_enable=1, pc_ctrl=0 (PC+4); -> FULL.
    - resp_valid && redirect: discard response -> REQ.
    - !resp_valid && redirect -> DROP.
  - DROP: imem_req_valid=0. resp_valid -> REQ, response discarded. A further redirect updates the PC only; stay in DROP until a response arrives.
  - FULL: id_valid=1.
    - id_ready -> id_valid=0, -> REQ.
    - redirect -> id_valid=0, -> REQ; redirect wins over id_ready in the same cycle.
- pc_enable is never asserted in HOLD. pc_ctrl=1 only when redirect is asserted.
- Throughput: one instruction per 3 cycles with zero-latency memory (REQ, WAIT, FULL). At most one request outstanding.
- imem_resp_valid outside WAIT/DROP is ignored.
- Reset asserted mid-fetch: all state cleared immediately. A late response after reset is ignored because the block is in HOLD.

Decomposition:
- Shared macro/package: FSM state encoding (HOLD, REQ, WAIT, DROP, FULL; 3 bits), RESET_PC 64'h0000_0000_8000_0000, redirect priority order.
- One combinational sub-module, ysyx_22041461_redirect_sel: inputs are the three valid/target pairs; outputs are redirect and pc_next.

Test Plan:
- Reset release, pc=0x80000000, ready=1, 1-cycle response 0x00000013, id_ready=1 -> req addr 0x80000000 at cycle 2 after release; id_valid with id_pc=0x80000000; pc_enable=1, pc_ctrl=0 in the WAIT cycle.
- Redirect in WAIT: jump_valid, jump_target=0x80000100, before response -> pc_ctrl=1, pc_next=0x80000100; the later response is dropped (id_valid stays 0); next request addr=0x80000100.
- Simultaneous trap (0x80000800), mret (0x80000400), jump (0x80000100) -> pc_next=0x80000800. Without trap -> 0x80000400.
- FULL with id_ready=0 for 5 cycles -> id_valid, id_inst, id_pc stable; no imem_req_valid; id_ready=1 -> REQ next cycle.
- imem_req_ready=0 for 4 cycles, then jump to 0x80000200 -> no DROP; the next accepted request carries 0x80000200.
- rst pulled low while in WAIT -> outputs reset immediately; a response arriving during HOLD produces no id_valid.
